// File: rtl/mm_arb_pkg.sv
// Shared encodings and parameter defaults for the two-requester main-memory arbiter.
package mm_arb_pkg;

    localparam int unsigned LINE_W_DEF = 256;
    localparam int unsigned ADDR_W_DEF = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

endpackage

// File: rtl/mm_rr_pick.sv
// Combinational two-way round-robin pick; i_last = 1 means requester 1 won most recently.
module mm_rr_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_gnt0,
    output logic o_gnt1
);

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt0 = i_last;
            o_gnt1 = !i_last;
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
    end

endmodule

// File: rtl/mm_arb.sv
// Shares one main-memory port between two requesters, one transaction in flight at a time.
module mm_arb
    import mm_arb_pkg::*;
#(
    parameter int unsigned LINE_W  = LINE_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   r0_a,
    input  logic [LINE_W/8-1:0] r0_be,
    input  logic [LINE_W-1:0]   r0_wd,
    input  logic                r0_read,
    input  logic                r0_write,
    output logic                r0_ack,
    output logic [LINE_W-1:0]   r0_rd,
    output logic                r0_rd_valid,
    output logic                r0_err,
    input  logic [ADDR_W-1:0]   r1_a,
    input  logic [LINE_W/8-1:0] r1_be,
    input  logic [LINE_W-1:0]   r1_wd,
    input  logic                r1_read,
    input  logic                r1_write,
    output logic                r1_ack,
    output logic [LINE_W-1:0]   r1_rd,
    output logic                r1_rd_valid,
    output logic                r1_err,
    output logic [ADDR_W-1:0]   mm_a,
    output logic [LINE_W/8-1:0] mm_be,
    output logic [LINE_W-1:0]   mm_wd,
    output logic                mm_read,
    output logic                mm_write,
    input  logic [LINE_W-1:0]   mm_rd,
    input  logic                mm_readdata_valid
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    logic [1:0]          r_state;
    logic                r_last;
    logic                r_owner;
    logic                r_is_wr;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_mm_a;
    logic [LINE_W/8-1:0] r_mm_be;
    logic [LINE_W-1:0]   r_mm_wd;
    logic                r_mm_read;
    logic                r_mm_write;
    logic                r_ack0;
    logic                r_ack1;
    logic [LINE_W-1:0]   r_rd0;
    logic [LINE_W-1:0]   r_rd1;
    logic                r_rdv0;
    logic                r_rdv1;
    logic                r_err0;
    logic                r_err1;

    logic w_req0;
    logic w_req1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_wr;

    assign w_req0 = r0_read | r0_write;
    assign w_req1 = r1_read | r1_write;
    // Write wins when a requester raises both strobes.
    assign w_wr   = w_gnt1 ? r1_write : r0_write;

    mm_rr_pick u_pick (
        .i_req0 (w_req0),
        .i_req1 (w_req1),
        .i_last (r_last),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_is_wr    <= 1'b0;
            r_cnt      <= '0;
            r_mm_a     <= '0;
            r_mm_be    <= '0;
            r_mm_wd    <= '0;
            r_mm_read  <= 1'b0;
            r_mm_write <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rd0      <= '0;
            r_rd1      <= '0;
            r_rdv0     <= 1'b0;
            r_rdv1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
        end else begin
            r_mm_read  <= 1'b0;
            r_mm_write <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdv0     <= 1'b0;
            r_rdv1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_owner    <= w_gnt1;
                        r_last     <= w_gnt1;
                        r_is_wr    <= w_wr;
                        r_mm_a     <= w_gnt1 ? r1_a  : r0_a;
                        r_mm_be    <= w_gnt1 ? r1_be : r0_be;
                        r_mm_wd    <= w_gnt1 ? r1_wd : r0_wd;
                        r_mm_write <= w_wr;
                        r_mm_read  <= !w_wr;
                        r_ack0     <= w_gnt0;
                        r_ack1     <= w_gnt1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= r_is_wr ? ST_IDLE : ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (mm_readdata_valid) begin
                        if (r_owner) begin
                            r_rd1  <= mm_rd;
                            r_rdv1 <= 1'b1;
                        end else begin
                            r_rd0  <= mm_rd;
                            r_rdv0 <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_err0  <= !r_owner;
                        r_err1  <= r_owner;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mm_a        = r_mm_a;
    assign mm_be       = r_mm_be;
    assign mm_wd       = r_mm_wd;
    assign mm_read     = r_mm_read;
    assign mm_write    = r_mm_write;
    assign r0_ack      = r_ack0;
    assign r1_ack      = r_ack1;
    assign r0_rd       = r_rd0;
    assign r1_rd       = r_rd1;
    assign r0_rd_valid = r_rdv0;
    assign r1_rd_valid = r_rdv1;
    assign r0_err      = r_err0;
    assign r1_err      = r_err1;

endmodule
